sw_debounce: RTL and testbench

//   Input-side conditioner for the board slide switches and push-buttons.

---
 rtl/sw_debounce_if.sv | 30 +++
 rtl/sw_debounce.sv | 76 +++++++
 tb/tb_sw_debounce.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_debounce_if.sv
// Switch conditioner bus: raw levels in, debounced levels and edge pulses out.
interface sw_debounce_if #(
  parameter int unsigned WIDTH = 2
);

  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  // Board/pin side: drives raw levels, consumes conditioned state.
  modport master (
    output sw_in,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );

  // Conditioner side.
  modport slave (
    input  sw_in,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );

endinterface

// File: rtl/sw_debounce.sv
// Per-bit switch synchroniser and bounce filter with registered edge pulses.
module sw_debounce #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  sw_debounce_if.slave      bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            s1_q;
  logic [WIDTH-1:0]            s2_q;
  logic [WIDTH-1:0]            clean_q, clean_d;
  logic [WIDTH-1:0]            rise_q,  rise_d;
  logic [WIDTH-1:0]            fall_q,  fall_d;
  logic                        changed_q, changed_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q,   cnt_d;

  // Two-flop synchroniser; only s2 is trusted downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.sw_in;
      s2_q <= s1_q;
    end
  end

  // Stability counter per bit: any agreement with the clean level restarts the window.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (s2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        clean_d[i] = s2_q[i];
        rise_d[i]  = s2_q[i];
        fall_d[i]  = ~s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  // Filter state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.sw_clean   = clean_q;
  assign bus.sw_rise    = rise_q;
  assign bus.sw_fall    = fall_q;
  assign bus.sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with a sliding-window reference model.
module tb_sw_debounce;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned N     = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sw_debounce_if #(.WIDTH(WIDTH)) bus ();

  sw_debounce #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a bit accepts a new level once the synchronised input
  // (raw input sampled two edges earlier) has disagreed with the clean level
  // for the last N edges in a row.
  logic [1:0] m_clean   = '0;
  logic [1:0] m_rise    = '0;
  logic [1:0] m_fall    = '0;
  logic       m_changed = 1'b0;
  logic [1:0] hq[$];
  logic [1:0] m_nc, m_nr, m_nf;
  logic       m_all, m_v;
  int         m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hq.delete();
      m_clean   = '0;
      m_rise    = '0;
      m_fall    = '0;
      m_changed = 1'b0;
    end else begin
      m_nc = m_clean;
      m_nr = '0;
      m_nf = '0;
      for (int b = 0; b < 2; b++) begin
        m_all = 1'b1;
        for (int j = 0; j < int'(N); j++) begin
          m_idx = hq.size() - 2 - j;
          m_v   = (m_idx >= 0) ? hq[m_idx][b] : 1'b0;
          if (m_v == m_clean[b]) m_all = 1'b0;
        end
        if (m_all) begin
          m_nc[b] = ~m_clean[b];
          m_nr[b] = m_nc[b];
          m_nf[b] = ~m_nc[b];
        end
      end
      m_clean   = m_nc;
      m_rise    = m_nr;
      m_fall    = m_nf;
      m_changed = |(m_nr | m_nf);
      hq.push_back(bus.sw_in);
      if (hq.size() > 32) void'(hq.pop_front());
    end
  end

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.sw_in  = 2'b00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed} !== 7'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got clean=%b rise=%b fall=%b chg=%b want all 0",
                 c, bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed} !== 7'd0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got clean=%b rise=%b fall=%b chg=%b want all 0",
                 c, bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed);
      end
    end
  endtask

  task automatic test_clean_step();
    int first;
    int rises;
    first = 0;
    rises = 0;
    bus.sw_in = 2'b01;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed} !==
          {m_clean, m_rise, m_fall, m_changed}) begin
        errors++;
        $display("FAIL step_model e=%0d got %b/%b/%b/%b want %b/%b/%b/%b", e,
                 bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed,
                 m_clean, m_rise, m_fall, m_changed);
      end
      if (bus.sw_rise !== 2'b00) begin
        rises++;
        if (first == 0) first = e;
        checks++;
        if (bus.sw_rise !== 2'b01 || bus.sw_changed !== 1'b1 || bus.sw_clean !== 2'b01) begin
          errors++;
          $display("FAIL step_pulse got rise=%b chg=%b clean=%b want 01/1/01",
                   bus.sw_rise, bus.sw_changed, bus.sw_clean);
        end
      end
    end
    checks++;
    if (first != 6) begin
      errors++;
      $display("FAIL step_latency got %0d edges want 6", first);
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL step_rise_count got %0d want 1", rises);
    end
  endtask

  task automatic test_bounce();
    int rises;
    int first;
    rises = 0;
    first = 0;
    bus.sw_in = 2'b00;
    for (int c = 0; c < 10; c++) @(negedge clk);
    checks++;
    if (bus.sw_clean !== 2'b00) begin
      errors++;
      $display("FAIL bounce_prep got clean=%b want 00", bus.sw_clean);
    end
    for (int p = 0; p < 4; p++) begin
      bus.sw_in = (p % 2 == 0) ? 2'b01 : 2'b00;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        if (bus.sw_rise[0]) rises++;
        checks++;
        if ({bus.sw_clean, bus.sw_rise, bus.sw_fall} !== {m_clean, m_rise, m_fall}) begin
          errors++;
          $display("FAIL bounce_model p=%0d got %b/%b/%b want %b/%b/%b", p,
                   bus.sw_clean, bus.sw_rise, bus.sw_fall, m_clean, m_rise, m_fall);
        end
      end
    end
    bus.sw_in = 2'b01;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (bus.sw_rise[0]) begin
        rises++;
        if (first == 0) first = e;
      end
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall} !== {m_clean, m_rise, m_fall}) begin
        errors++;
        $display("FAIL bounce_model_hold e=%0d got %b/%b/%b want %b/%b/%b", e,
                 bus.sw_clean, bus.sw_rise, bus.sw_fall, m_clean, m_rise, m_fall);
      end
    end
    checks++;
    if (rises != 1 || first != 6) begin
      errors++;
      $display("FAIL bounce_single_rise got rises=%0d at edge %0d want 1 at 6", rises, first);
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    bus.sw_in = 2'b11;
    for (int c = 0; c < 3; c++) @(negedge clk);
    bus.sw_in = 2'b01;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.sw_clean[1] !== 1'b0 || bus.sw_rise[1] !== 1'b0 || bus.sw_fall[1] !== 1'b0) bad++;
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall} !== {m_clean, m_rise, m_fall}) begin
        errors++;
        $display("FAIL glitch_model c=%0d got %b/%b/%b want %b/%b/%b", c,
                 bus.sw_clean, bus.sw_rise, bus.sw_fall, m_clean, m_rise, m_fall);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch_filtered got %0d disturbed cycles on bit1 want 0", bad);
    end
  endtask

  task automatic test_both_fall();
    int falls;
    int chgs;
    falls = 0;
    chgs  = 0;
    bus.sw_in = 2'b11;
    for (int c = 0; c < 10; c++) @(negedge clk);
    checks++;
    if (bus.sw_clean !== 2'b11) begin
      errors++;
      $display("FAIL fall_prep got clean=%b want 11", bus.sw_clean);
    end
    bus.sw_in = 2'b00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.sw_changed === 1'b1) chgs++;
      if (bus.sw_fall !== 2'b00) begin
        falls++;
        checks++;
        if (bus.sw_fall !== 2'b11 || bus.sw_changed !== 1'b1 || bus.sw_rise !== 2'b00) begin
          errors++;
          $display("FAIL fall_pulse got fall=%b chg=%b rise=%b want 11/1/00",
                   bus.sw_fall, bus.sw_changed, bus.sw_rise);
        end
      end
    end
    checks++;
    if (falls != 1 || chgs != 1 || bus.sw_clean !== 2'b00) begin
      errors++;
      $display("FAIL fall_count got falls=%0d chg=%0d clean=%b want 1/1/00",
               falls, chgs, bus.sw_clean);
    end
  endtask

  task automatic test_reset_mid();
    int first;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        bus.sw_in = 2'b10;
        for (int c = 0; c < 3; c++) @(negedge clk);
      end else begin
        for (int c = 0; c < 4; c++) @(negedge clk);
        checks++;
        if (bus.sw_clean !== 2'b10) begin
          errors++;
          $display("FAIL rst_steady_pre got clean=%b want 10", bus.sw_clean);
        end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed} !== 7'd0) begin
        errors++;
        $display("FAIL rst_assert r=%0d got clean=%b rise=%b fall=%b chg=%b want all 0",
                 r, bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      first = 0;
      for (int e = 1; e <= 12; e++) begin
        @(negedge clk);
        if (first == 0 && bus.sw_rise !== 2'b00) begin
          first = e;
          checks++;
          if (bus.sw_rise !== 2'b10 || bus.sw_clean !== 2'b10 || bus.sw_changed !== 1'b1) begin
            errors++;
            $display("FAIL rst_rise r=%0d got rise=%b clean=%b chg=%b want 10/10/1",
                     r, bus.sw_rise, bus.sw_clean, bus.sw_changed);
          end
        end
      end
      checks++;
      if (first != 6) begin
        errors++;
        $display("FAIL rst_latency r=%0d got %0d edges want 6", r, first);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) bus.sw_in = bus.sw_in ^ 2'($urandom_range(1, 3));
      @(negedge clk);
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed} !==
          {m_clean, m_rise, m_fall, m_changed}) begin
        errors++;
        $display("FAIL random_model c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c,
                 bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed,
                 m_clean, m_rise, m_fall, m_changed);
      end
      checks++;
      if ((bus.sw_rise & bus.sw_fall) !== 2'b00) begin
        errors++;
        $display("FAIL random_rise_and_fall c=%0d got rise=%b fall=%b want disjoint",
                 c, bus.sw_rise, bus.sw_fall);
      end
    end
  endtask

  initial begin
    bus.sw_in = 2'b00;
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_both_fall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
